// File: rtl/mux_arb_2to1.sv
// Two-requester burst arbiter driving one registered shared data path.
// Ownership ends on req drop, a last beat, or MAX_BEATS; priority rotates on every release.
module mux_arb_2to1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             last0,
  input  logic             last1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             yValid_q, yValid_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

  logic             owned;
  logic             ownReq;
  logic             ownLast;
  logic             otherReq;
  logic             beat;
  logic             relOwner;
  logic [WIDTH-1:0] ownData;
  logic [CNT_W-1:0] cntInc;

  always_comb begin
    owned    = (state_q == OWN0) || (state_q == OWN1);
    ownReq   = (state_q == OWN1) ? req1  : req0;
    ownLast  = (state_q == OWN1) ? last1 : last0;
    ownData  = (state_q == OWN1) ? d1    : d0;
    otherReq = (state_q == OWN1) ? req0  : req1;
    beat     = owned && ownReq;
    cntInc   = beatCnt_q + CNT_W'(1);
    // A dropped req releases without a beat; otherwise the beat itself may end the grant.
    relOwner = owned && (!ownReq || (beat && (ownLast || (cntInc == MAX_CNT))));
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    beatCnt_d = beatCnt_q;
    unique case (state_q)
      IDLE: begin
        beatCnt_d = '0;
        if (req0 && (!req1 || !prio_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (relOwner) begin
          prio_d    = (state_q == OWN0);
          beatCnt_d = '0;
          if (otherReq) begin
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          beatCnt_d = cntInc;
        end
      end
      default: begin
        state_d   = IDLE;
        beatCnt_d = '0;
      end
    endcase
  end

  // sel follows the owner being entered and keeps the last owner while idle.
  always_comb begin
    sel_d = sel_q;
    if (state_d == OWN0) begin
      sel_d = 1'b0;
    end else if (state_d == OWN1) begin
      sel_d = 1'b1;
    end
    y_d      = beat ? ownData : y_q;
    yValid_d = beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      y_q       <= '0;
      yValid_q  <= 1'b0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      yValid_q  <= yValid_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = yValid_q;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed bench for mux_arb_2to1 (WIDTH=8, MAX_BEATS=4) with a per-cycle grant/valid monitor.
module tb_mux_arb_2to1;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, last0, last1;
  logic [7:0] d0, d1;
  logic       gnt0, gnt1, sel, y_valid;
  logic [7:0] y;

  int errors = 0;
  int checks = 0;
  logic beatPrev;

  mux_arb_2to1 #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic g0, input logic g1, input logic s,
                            input logic yv, input logic [7:0] yy);
    checkOutput({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
    checkOutput({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
    checkOutput({tag, ".sel"}, 32'(sel), 32'(s));
    checkOutput({tag, ".y_valid"}, 32'(y_valid), 32'(yv));
    checkOutput({tag, ".y"}, 32'(y), 32'(yy));
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic l0, input logic l1,
                               input logic [7:0] dd0, input logic [7:0] dd1);
    req0  = r0;
    req1  = r1;
    last0 = l0;
    last1 = l1;
    d0    = dd0;
    d1    = dd1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // A beat is a granted cycle with the owner's req high; y_valid must follow one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beatPrev <= 1'b0;
    else        beatPrev <= (gnt0 && req0) || (gnt1 && req1);
  end

  always @(negedge clk) begin
    checkOutput("mon.exclusive", 32'(gnt0 & gnt1), 32'd0);
    checkOutput("mon.yvalid", 32'(y_valid), 32'(rst_n ? beatPrev : 1'b0));
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    applyStimulus(1, 1, 0, 0, 8'h11, 8'h00);
    tick();
    checkState("reset", 0, 0, 0, 0, 8'h00);

    // Single requester with last on the third beat
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 8'h11, 8'h00);
    tick();
    checkState("s1.grant", 1, 0, 0, 0, 8'h00);
    tick();
    checkState("s1.b0", 1, 0, 0, 1, 8'h11);
    applyStimulus(1, 0, 0, 0, 8'h22, 8'h00);
    tick();
    checkState("s1.b1", 1, 0, 0, 1, 8'h22);
    applyStimulus(1, 0, 1, 0, 8'h33, 8'h00);
    tick();
    checkState("s1.b2", 0, 0, 0, 1, 8'h33);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    checkState("s1.idle", 0, 0, 0, 0, 8'h33);

    rst_n = 1'b0;
    tick();
    checkState("s2.reset", 0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;

    // Contention from reset: 4 beats each, handover with no bubble
    applyStimulus(1, 1, 0, 0, 8'hA0, 8'hB0);
    tick();
    checkState("s2.grant0", 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 8'(8'hA0 + i), 8'hB0);
      tick();
      checkState($sformatf("s2.own0_%0d", i), i < 3, i == 3, i == 3, 1, 8'(8'hA0 + i));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 8'hA0, 8'(8'hB0 + i));
      tick();
      checkState($sformatf("s2.own1_%0d", i), i == 3, i < 3, i < 3, 1, 8'(8'hB0 + i));
    end
    applyStimulus(1, 1, 0, 0, 8'hC0, 8'hB0);
    tick();
    checkState("s2.own0_again", 1, 0, 0, 1, 8'hC0);
    applyStimulus(0, 0, 0, 0, 8'hC0, 8'hB0);
    tick();
    checkState("s2.drop", 0, 0, 0, 0, 8'hC0);

    // Early drop by requester 1 after two beats while requester 0 waits
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h51);
    tick();
    checkState("s3.grant1", 0, 1, 1, 0, 8'hC0);
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h51);
    tick();
    checkState("s3.b0", 0, 1, 1, 1, 8'h51);
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h52);
    tick();
    checkState("s3.b1", 0, 1, 1, 1, 8'h52);
    applyStimulus(1, 0, 0, 0, 8'h61, 8'h52);
    tick();
    checkState("s3.handover", 1, 0, 0, 0, 8'h52);
    tick();
    checkState("s3.own0", 1, 0, 0, 1, 8'h61);
    applyStimulus(0, 0, 0, 0, 8'h61, 8'h00);
    tick();
    checkState("s3.idle", 0, 0, 0, 0, 8'h61);

    // Zero-beat grant, then contention must favour requester 0
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h99);
    tick();
    checkState("s4.grant1", 0, 1, 1, 0, 8'h61);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h99);
    tick();
    checkState("s4.zero", 0, 0, 1, 0, 8'h61);
    applyStimulus(1, 1, 0, 0, 8'h81, 8'h91);
    tick();
    checkState("s4.prio", 1, 0, 0, 0, 8'h61);
    applyStimulus(0, 0, 0, 0, 8'h81, 8'h91);
    tick();
    checkState("s4.idle", 0, 0, 0, 0, 8'h61);

    // Reset asserted during the second beat cycle of OWN0
    applyStimulus(1, 0, 0, 0, 8'h71, 8'h00);
    tick();
    checkState("s5.grant", 1, 0, 0, 0, 8'h61);
    tick();
    checkState("s5.b0", 1, 0, 0, 1, 8'h71);
    applyStimulus(1, 0, 0, 0, 8'h72, 8'h00);
    #2 rst_n = 1'b0;
    #1 checkState("s5.async", 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    checkState("s5.held", 0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;
    tick();
    checkState("s5.resume", 1, 0, 0, 0, 8'h00);
    tick();
    checkState("s5.b0again", 1, 0, 0, 1, 8'h72);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    checkState("s5.idle", 0, 0, 0, 0, 8'h72);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_2to1.md
MUX_ARB_2TO1 -- requirements
Module: mux_arb_2to1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each requester and of the output.
REQ-002 The block SHALL have parameter MAX_BEATS, default 4, giving the maximum beats per grant; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  requester 0/1 asks for the shared path; while granted, each high cycle is one beat.
REQ-006 last0, last1  input  1 each  final beat marker, sampled only on a beat of the owning requester.
REQ-007 d0, d1  input  WIDTH each  requester data, sampled only on a beat of the owning requester.
REQ-008 gnt0, gnt1  output  1 each  grant, driven directly from the state register; never both high.
REQ-009 sel  output  1  mux select: 0 = d0, 1 = d1; reflects the current or most recent owner.
REQ-010 y  output  WIDTH  registered shared-path data.
REQ-011 y_valid  output  1  registered; high for exactly one cycle per accepted beat.

Function
REQ-012 The FSM SHALL have three states: IDLE, OWN0 and OWN1; gnt0 = (state==OWN0) and gnt1 = (state==OWN1).
REQ-013 The block SHALL keep a one-bit priority pointer prio; prio=0 favours requester 0 and prio=1 favours requester 1.
REQ-014 In IDLE, the FSM SHALL move to OWN0 if only req0 is high, to OWN1 if only req1 is high, and to OWN(prio) if both are high; with neither high it SHALL stay in IDLE.
REQ-015 A beat SHALL occur in a cycle where state==OWN0 with req0=1, or state==OWN1 with req1=1.
REQ-016 On each beat the block SHALL register y <= owner data and y_valid <= 1; in non-beat cycles y_valid <= 0 and y SHALL hold its value.
REQ-017 Latency: a requester seeing gnt high in cycle t with req high SHALL see its d on y, with y_valid=1, in cycle t+1.
REQ-018 A per-grant beat counter SHALL clear on every grant entry and increment on every beat.
REQ-019 The owner SHALL be released at the end of a cycle in which any of the following holds:
  - owner req is low;
  - a beat carries last=1;
  - the beat count reaches MAX_BEATS.
REQ-020 On release, prio SHALL point to the other requester.
REQ-021 On release, if the other requester's req is high in that cycle, the FSM SHALL go directly to that requester's OWN state with no IDLE bubble; otherwise it SHALL go to IDLE.
REQ-022 Release caused by req low SHALL produce no beat in that cycle.
REQ-023 A requester SHALL never be re-granted immediately after its own release while the other requester's req is high, because both arbitration and prio favour the other.
REQ-024 sel SHALL update on entry to OWN0 (to 0) or OWN1 (to 1) and SHALL hold its value in IDLE.
REQ-025 With MAX_BEATS=1, every beat SHALL release the grant, giving strict alternation under continuous dual requests.
REQ-026 Deasserting req in the same cycle as entry into OWN SHALL release with zero beats; y_valid stays 0 and prio still toggles.
REQ-027 The counter SHALL be wide enough for MAX_BEATS and SHALL never wrap within a grant.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state=IDLE, gnt0=0, gnt1=0, sel=0, prio=0, y=0, y_valid=0, beat counter=0; this takes effect immediately, independent of clk.
REQ-029 Reset asserted mid-grant SHALL abort the transfer with no further y_valid.
REQ-030 After rst_n rises, the first arbitration SHALL occur on the next rising clk edge.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - Single requester: req0=1 continuously, d0=0x11,0x22,0x33, last0 on 0x33 -> gnt0 one cycle after req; y=0x11,0x22,0x33 on consecutive cycles with y_valid; then IDLE, gnt0=0.
  - Contention from reset: req0=req1=1 in the same cycle, no last, MAX_BEATS=4 -> OWN0 for 4 beats, then OWN1 directly for 4 beats, then OWN0, with y_valid never low between grants.
  - Early drop: requester 1 granted and drops req1 after 2 beats while req0=1 -> exactly 2 y_valid pulses with sel=1, then gnt0 the next cycle with sel=0.
  - Zero-beat grant: req1 pulsed for one cycle only -> gnt1 high one cycle, y_valid stays 0, prio=0 afterwards.
  - Reset mid-burst: rst_n low during the beat-2 cycle of OWN0 -> gnt0, y, y_valid and sel go to 0 immediately; with req0=1 held, the grant resumes one edge after rst_n rises.
  - Assertion, checked every cycle in all tests: gnt0 & gnt1 never high together, and y_valid high only in the cycle after a beat.
